// File: rtl/serial_sched_pkg.sv
// Shared types and defaults for the serial result scheduler.
// state_t, default parameters, and the round-robin wrap helper.
package serial_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    DONE
  } state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_REQ_INDEX_BITS = 2;
  localparam int DEF_NUMBER_BITS    = 37;
  localparam int DEF_TIMEOUT_CYCLES = 1023;

  // Index that follows idx in a ring of n requesters.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first high req at or after ptr.
// Ports: req, ptr in; valid, index out. NUM_REQ need not be 2**k.
module rr_arbiter
  import serial_sched_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int REQ_INDEX_BITS = DEF_REQ_INDEX_BITS
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [REQ_INDEX_BITS-1:0] ptr,
  output logic                      valid,
  output logic [REQ_INDEX_BITS-1:0] index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!valid && req[k] &&
            k == (int'(ptr) + i) % NUM_REQ) begin
          valid = 1'b1;
          index = REQ_INDEX_BITS'(k);
        end
      end
    end
  end

endmodule

// File: rtl/serial_result_scheduler.sv
// Shares one serial number encoder between NUM_REQ result producers.
// In: clk, reset, req, nums, enc_available. Out: ack, grant_index,
// busy, error, enc_num, enc_ready. Option: SERIAL_RESULT_SCHEDULER_TIMEOUT_EN.
module serial_result_scheduler
  import serial_sched_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int REQ_INDEX_BITS = DEF_REQ_INDEX_BITS,
  parameter int NUMBER_BITS    = DEF_NUMBER_BITS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*NUMBER_BITS-1:0] nums,
  output logic [NUM_REQ-1:0]             ack,
  output logic [REQ_INDEX_BITS-1:0]      grant_index,
  output logic                           busy,
  output logic                           error,
  output logic [NUMBER_BITS-1:0]         enc_num,
  output logic                           enc_ready,
  input  logic                           enc_available
);

  state_t                    state_q, state_d;
  logic [NUMBER_BITS-1:0]    num_q, num_d;
  logic                      rdy_q, rdy_d;
  logic [NUM_REQ-1:0]        ack_q, ack_d;
  logic                      busy_q, busy_d;
  logic [REQ_INDEX_BITS-1:0] gidx_q, gidx_d;
  logic [REQ_INDEX_BITS-1:0] ptr_q, ptr_d;

  logic                      arb_valid;
  logic [REQ_INDEX_BITS-1:0] arb_idx;
  logic [NUMBER_BITS-1:0]    sel_num;
  logic [NUM_REQ-1:0]        ack_hot;

  rr_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .REQ_INDEX_BITS(REQ_INDEX_BITS)
  ) u_arb (
    .req  (req),
    .ptr  (ptr_q),
    .valid(arb_valid),
    .index(arb_idx)
  );

  always_comb begin
    sel_num = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_idx == REQ_INDEX_BITS'(k)) begin
        sel_num = nums[k*NUMBER_BITS +: NUMBER_BITS];
      end
    end
  end

  always_comb begin
    ack_hot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      ack_hot[k] = (gidx_q == REQ_INDEX_BITS'(k));
    end
  end

`ifdef SERIAL_RESULT_SCHEDULER_TIMEOUT_EN
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                tmo;
  assign tmo = (cnt_q == CNT_BITS'(TIMEOUT_CYCLES));
`endif

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    rdy_d   = rdy_q;
    ack_d   = '0;
    busy_d  = busy_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
`ifdef SERIAL_RESULT_SCHEDULER_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        rdy_d  = 1'b0;
        busy_d = 1'b0;
        if (arb_valid && enc_available) begin
          num_d   = sel_num;
          gidx_d  = arb_idx;
          rdy_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Encoder takes the number when it drops available.
        if (!enc_available) begin
          rdy_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (enc_available) begin
          ack_d   = ack_hot;
          ptr_d   = REQ_INDEX_BITS'(
                      next_index(int'(gidx_q), NUM_REQ));
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        num_d   = '0;
        rdy_d   = 1'b0;
        busy_d  = 1'b0;
        gidx_d  = '0;
      end
    endcase
`ifdef SERIAL_RESULT_SCHEDULER_TIMEOUT_EN
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == ISSUE || state_q == BUSY) begin
      if (tmo) begin
        // Abandon; request stays pending, pointer unchanged.
        rdy_d   = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      rdy_q   <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef SERIAL_RESULT_SCHEDULER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign error = err_q;
`else
  // Constant 0: no watchdog in this build.
  assign error = (TIMEOUT_CYCLES < 0);
`endif

  assign enc_num     = num_q;
  assign enc_ready   = rdy_q;
  assign ack         = ack_q;
  assign busy        = busy_q;
  assign grant_index = gidx_q;

endmodule

// File: doc/serial_result_scheduler.md
Name: serial_result_scheduler

Overview:
- Shares one serial_number_encoder between NUM_REQ result producers, e.g. amplitude readout and measurement counters.
- Round-robin arbitrates requests, latches the winning number, and drives the encoder ready/available handshake.
- Acknowledges the requester only once the encoder has finished all bytes.
- Sits between the compute datapath and the encoder/UART transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (>=1, not required to be a power of two).
- REQ_INDEX_BITS, 2, width of the requester index; must satisfy 2**REQ_INDEX_BITS >= NUM_REQ.
- NUMBER_BITS, 37, width of each signed number; must match the encoder.
- TIMEOUT_CYCLES, 1023, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high with its number stable until ack.
- nums  in  NUM_REQ*NUMBER_BITS  flattened signed numbers; requester k uses bits [k*NUMBER_BITS +: NUMBER_BITS].
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- grant_index  out  REQ_INDEX_BITS  index of the current or last granted requester.
- busy  out  1  high from grant until the cycle after ack.
- error  out  1  sticky encoder-timeout flag; tied 0 when the optional feature is absent.
- enc_num  out  NUMBER_BITS  number presented to the encoder.
- enc_ready  out  1  encoder start request.
- enc_available  in  1  encoder idle indication.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE
  - enc_ready=0, enc_num=0, ack=0, busy=0, grant_index=0, error=0
  - rr pointer=0, so requester 0 has first priority.
- IDLE:
  - When any req is high and enc_available=1: select the first high req at or cyclically after the pointer.
  - On that edge: register enc_num from the selected slice, set grant_index, enc_ready=1, busy=1; go to ISSUE.
  - Latency from req high to enc_ready high is 1 cycle.
  - If enc_available=0, wait in IDLE; no grant is made.
- ISSUE:
  - Hold enc_ready=1 until enc_available is sampled 0, i.e. the encoder has accepted.
  - On that edge: enc_ready<=0; go to BUSY.
- BUSY:
  - Wait for enc_available sampled 1, meaning the encoder has sent its last byte.
  - On that edge: ack[grant_index]<=1; pointer<=(grant_index+1) wrapping at NUM_REQ; go to DONE.
- DONE (one cycle):
  - ack is high during this cycle. The requester must drop req, or present its next number, by the next edge.
  - Next edge: ack<=0, busy<=0; go to IDLE.
  - A new grant is therefore earliest 2 cycles after ack.
- Hold rules:
  - enc_num is stable from ISSUE through DONE. nums changes after the grant are ignored.
  - req dropping mid-transfer is ignored; the transfer completes and ack still pulses.
- Simultaneous requests are served strictly round-robin; each requester receives at most one grant per NUM_REQ grants while the others are pending.
- With NUM_REQ=1: the pointer stays 0 and grant_index is always 0.
- Reset mid-transfer aborts immediately to the reset values; no ack is issued. The encoder shares the same reset.
- A state encoding outside the defined states recovers to IDLE with outputs cleared.

Optional Feature:
- Macro: SERIAL_RESULT_SCHEDULER_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ISSUE and on entry to BUSY, and increments in those states.
  - If it reaches TIMEOUT_CYCLES: enc_ready<=0, error<=1 (sticky until reset), go to IDLE, no ack.
  - The request stays pending and is re-arbitrated from the same pointer.
- Undefined: no counter exists, error is tied 0, and the scheduler waits indefinitely.

Decomposition:
- Package serial_sched_pkg:
  - state enum {IDLE, ISSUE, BUSY, DONE}
  - default parameter constants
  - function next_index(idx, n) implementing the wrap.
- Sub-module rr_arbiter:
  - Inputs: req vector and pointer.
  - Outputs: valid and grant index.
  - Purely combinational; reusable for other shared UART sources.

Test Plan:
- Reset, then req=0001, nums[0]=37'h1_2345_6789, encoder model with enc_available=1:
  - enc_ready high 1 cycle later, enc_num=37'h1_2345_6789.
  - enc_ready drops after enc_available falls.
  - ack=0001 exactly one cycle after enc_available rises.
- req=1111 held continuously, reacquired after each ack:
  - grant order 0,1,2,3,0.
  - busy drops for exactly 1 cycle between transfers.
- enc_available=0 when req arrives: no enc_ready until enc_available=1; then a normal transfer follows.
- Change nums[2] and drop req[2] during BUSY: enc_num keeps its original value and ack[2] still pulses.
- Assert reset in BUSY: all outputs return to reset values asynchronously; after release, req=0100 is served normally.
- With SERIAL_RESULT_SCHEDULER_TIMEOUT_EN, TIMEOUT_CYCLES=8, and enc_available stuck at 1 after enc_ready:
  - error=1 after 8 cycles, enc_ready=0, no ack.
  - The pending request is re-granted.
